// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Signals: start/a/b (request side), busy/done/d/bo (result side),
// ovf only when SERIAL_SUB_OVF_EN is defined.
// master: requester drives start/a/b. slave: the subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
        input  busy, done, d, bo
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, bo
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: d = (a - b) mod 2^WIDTH,
// bo = (a < b). One full-subtractor cell plus a borrow flop; one bit per clock.
// Ports: clk, rst_n (async active-low), bus (serial_subtractor_if.slave):
//   start/a/b in, busy/done/d/bo out (ovf out when SERIAL_SUB_OVF_EN is defined).
// Optional macro SERIAL_SUB_OVF_EN adds the registered signed-overflow flag ovf.
// A request is accepted in IDLE or DONE (back-to-back); done pulses one cycle
// WIDTH+1 cycles after acceptance; d/bo/ovf hold until the next DONE entry.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bo_q, bo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             diff_bit;
    logic             br_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current LSBs and the running borrow.
    always_comb begin
        diff_bit = ra_q[0] ^ rb_q[0] ^ br_q;
        br_next  = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        d_d     = d_q;
        bo_d    = bo_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                // Difference bits enter at the MSB so the LSB ends up at bit 0.
                res_d = WIDTH'({diff_bit, res_q} >> 1);
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    d_d     = res_d;
                    bo_d    = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (diff_bit != a_msb_q);
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): the driver pushes
// expected results, the monitor pops and compares on every done pulse.
module tb_serial_subtractor;
    localparam int unsigned WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.d   = WIDTH'(a - b);
        e.bo  = (a < b);
        e.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("d", 32'(bus.d), 32'(e.d));
                check("bo", 32'(bus.bo), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Raise start before an edge, optionally record the expectation, then
    // drop start and scramble a/b while the operation is in flight.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input exp_t e, input bit push);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
    endtask

    // Wait (bounded) for done; report how many busy samples preceded it.
    task automatic wait_done(output int busy_cycles);
        bit seen;
        seen = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles at %0t", $time);
        end
    endtask

    // Full operation: returns at the sample where done is high.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input exp_t e);
        int bc;
        issue(a, b, e, 1'b1);
        wait_done(bc);
        check("latency_busy", 32'(bc), 32'(WIDTH));
    endtask

    initial begin
        int bc;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_d", 32'(bus.d), 32'd0);
        check("rst_bo", 32'(bus.bo), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plan 1: 10 - 15 = 11 borrow 1
        run_op(4'd10, 4'd15, '{d: 4'd11, bo: 1'b1, ovf: 1'b0});
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Plan 2: directed vectors
        run_op(4'd0, 4'd1, '{d: 4'd15, bo: 1'b1, ovf: 1'b0});
        @(negedge clk);
        run_op(4'd15, 4'd10, '{d: 4'd5, bo: 1'b0, ovf: 1'b0});
        @(negedge clk);
        run_op(4'd7, 4'd7, '{d: 4'd0, bo: 1'b0, ovf: 1'b0});
        @(negedge clk);

        // Plan 3: second start while busy is ignored
        issue(4'd3, 4'd1, '{d: 4'd2, bo: 1'b0, ovf: 1'b0}, 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(bc);
        repeat (8) @(negedge clk);
        check("ignored_d_held", 32'(bus.d), 32'd2);
        check("ignored_idle", 32'(bus.busy), 32'd0);

        // Plan 4: back-to-back start in the done cycle
        run_op(4'd9, 4'd2, '{d: 4'd7, bo: 1'b0, ovf: 1'b1});
        issue(4'd12, 4'd4, '{d: 4'd8, bo: 1'b0, ovf: 1'b0}, 1'b1);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_d_held", 32'(bus.d), 32'd7);
        wait_done(bc);
        check("b2b_latency", 32'(bc), 32'(WIDTH));
        @(negedge clk);

        // Plan 5: async reset mid-operation, no done afterwards
        issue(4'd3, 4'd1, '{d: 4'd2, bo: 1'b0, ovf: 1'b0}, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_done", 32'(bus.done), 32'd0);
        check("async_d", 32'(bus.d), 32'd0);
        check("async_bo", 32'(bus.bo), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("async_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_idle", 32'(bus.busy), 32'd0);
        run_op(4'd5, 4'd6, '{d: 4'd15, bo: 1'b1, ovf: 1'b0});
        @(negedge clk);

        // Plan 6: overflow vectors, then exhaustive sweep against the model
        run_op(4'd8, 4'd1, '{d: 4'd7, bo: 1'b0, ovf: 1'b1});
        @(negedge clk);
        run_op(4'd5, 4'd3, '{d: 4'd2, bo: 1'b0, ovf: 1'b0});
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(WIDTH'(a), WIDTH'(b), model(WIDTH'(a), WIDTH'(b)));
                @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
